// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shadow scoreboard of in-flight instructions drives operand forwarding, load-use stalls and jump flushes.
// Zero-cycle combinational outputs from registered scoreboard; a stall holds decode and injects one bubble per cycle.
module hazard_forward_unit #(
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int JMP_STAGE  = 1,
  parameter int R0_ZERO    = 0,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_ra,
  input  logic [REG_AW-1:0] dec_rb,
  input  logic              dec_use_a,
  input  logic              dec_use_b,
  input  logic [REG_AW-1:0] dec_dest,
  input  logic              dec_wreg,
  input  logic              dec_load,
  input  logic              jmp_taken,
  output logic              stall,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              wreg;
    logic              load;
    logic [REG_AW-1:0] dest;
  } sb_entry_t;

  sb_entry_t        sb [DEPTH];
  logic             hz_a, hz_b;
  logic [DEPTH-1:0] kill;

  function automatic logic src_match(input sb_entry_t e, input logic [REG_AW-1:0] r,
                                     input logic rd);
    return e.v && e.wreg && rd && (e.dest == r) && (R0_ZERO == 0 || r != '0);
  endfunction

  // Walk from oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    hz_a      = 1'b0;
    hz_b      = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (src_match(sb[i], dec_ra, dec_use_a)) begin
        fwd_a_sel = SEL_W'(i + 1);
        hz_a      = sb[i].load && (i < LOAD_READY);
      end
      if (src_match(sb[i], dec_rb, dec_use_b)) begin
        fwd_b_sel = SEL_W'(i + 1);
        hz_b      = sb[i].load && (i < LOAD_READY);
      end
    end
  end

  assign flush = jmp_taken;
  assign stall = dec_valid && !jmp_taken && (hz_a || hz_b);

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = flush && (i < JMP_STAGE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      if (flush || stall) begin
        sb[0] <= '0;
      end else begin
        sb[0] <= '{v: dec_valid, wreg: dec_wreg, load: dec_load, dest: dec_dest};
      end
      for (int i = 1; i < DEPTH; i++) begin
        sb[i] <= '{v: sb[i-1].v && !kill[i-1], wreg: sb[i-1].wreg,
                   load: sb[i-1].load, dest: sb[i-1].dest};
      end
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three instances (defaults, R0 hardwired, 3-bit stall counter) share one stimulus stream.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_use_a, dec_use_b, dec_wreg, dec_load, jmp_taken;
  logic [3:0] dec_ra, dec_rb, dec_dest;

  logic        st0, fl0, st1, fl1, st2, fl2;
  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [31:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  hazard_forward_unit u_d0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dest(dec_dest), .dec_wreg(dec_wreg),
    .dec_load(dec_load), .jmp_taken(jmp_taken), .stall(st0), .flush(fl0),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(cnt0));

  hazard_forward_unit #(.R0_ZERO(1)) u_d1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dest(dec_dest), .dec_wreg(dec_wreg),
    .dec_load(dec_load), .jmp_taken(jmp_taken), .stall(st1), .flush(fl1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(cnt1));

  hazard_forward_unit #(.CNT_W(3)) u_d2 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dest(dec_dest), .dec_wreg(dec_wreg),
    .dec_load(dec_load), .jmp_taken(jmp_taken), .stall(st2), .flush(fl2),
    .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cnt(cnt2));

  localparam int S_STALL = 0, S_FLUSH = 1, S_FA = 2, S_FB = 3, S_CNT = 4;

  typedef struct {
    logic rst, dv;
    logic [3:0] ra, rb, dest;
    logic ua, ub, wreg, load, jmp;
    int st, fl, fa, fb, cnt;   // -1 = not checked this row
  } vec_t;

  typedef struct {
    string name;
    int    dut;
    int    sig;
    int    exp;
  } chk_t;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  function automatic vec_t mkv(input logic r, input logic dv, input logic [3:0] ra, input logic ua,
                               input logic [3:0] rb, input logic ub, input logic [3:0] dest,
                               input logic wreg, input logic load, input logic jmp,
                               input int st, input int fl, input int fa, input int fb, input int cnt);
    vec_t v;
    v.rst = r;  v.dv = dv;  v.ra = ra;  v.ua = ua;  v.rb = rb;  v.ub = ub;
    v.dest = dest;  v.wreg = wreg;  v.load = load;  v.jmp = jmp;
    v.st = st;  v.fl = fl;  v.fa = fa;  v.fb = fb;  v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] actual(input int dut, input int sig);
    logic [31:0] a;
    a = 'x;
    case (dut)
      0: case (sig) S_STALL: a = 32'(st0); S_FLUSH: a = 32'(fl0); S_FA: a = 32'(fa0);
                    S_FB: a = 32'(fb0); default: a = cnt0; endcase
      1: case (sig) S_STALL: a = 32'(st1); S_FLUSH: a = 32'(fl1); S_FA: a = 32'(fa1);
                    S_FB: a = 32'(fb1); default: a = cnt1; endcase
      default: case (sig) S_STALL: a = 32'(st2); S_FLUSH: a = 32'(fl2); S_FA: a = 32'(fa2);
                    S_FB: a = 32'(fb2); default: a = 32'(cnt2); endcase
    endcase
    return a;
  endfunction

  task automatic expect_val(input string name, input int dut, input int sig, input int e);
    chk_t c;
    if (e < 0) return;
    c.name = name;  c.dut = dut;  c.sig = sig;  c.exp = e;
    q.push_back(c);
  endtask

  task automatic check_all();
    chk_t        c;
    logic [31:0] a;
    while (q.size() > 0) begin
      c = q.pop_front();
      a = actual(c.dut, c.sig);
      checks++;
      if (a !== 32'(c.exp)) begin
        errors++;
        $display("FAIL %s (dut%0d): got %0d, expected %0d", c.name, c.dut, a, c.exp);
      end
    end
  endtask

  task automatic drv(input vec_t v);
    @(negedge clk);
    rst = v.rst;  dec_valid = v.dv;  dec_ra = v.ra;  dec_use_a = v.ua;  dec_rb = v.rb;
    dec_use_b = v.ub;  dec_dest = v.dest;  dec_wreg = v.wreg;  dec_load = v.load;
    jmp_taken = v.jmp;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;  dec_valid = 0;  dec_ra = 0;  dec_rb = 0;  dec_use_a = 0;  dec_use_b = 0;
    dec_dest = 0;  dec_wreg = 0;  dec_load = 0;  jmp_taken = 0;

    //                r  dv ra ua rb ub dst wr ld jp   st fl fa  fb  cnt
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0,  0));  // reset state
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 3,  1, 0, 0,   0, 0, 0,  0,  0));  // I1 writes r3
    tbl.push_back(mkv(0, 1, 3, 1, 0, 0, 4,  1, 0, 0,   0, 0, 1,  0, -1));  // I2 reads r3
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0, -1));  // bubble
    tbl.push_back(mkv(0, 1, 4, 1, 3, 1, 0,  0, 0, 0,   0, 0, 2,  3, -1));  // r4@1, r3@WB
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 5,  1, 1, 0,   0, 0, 0,  0,  0));  // load r5
    tbl.push_back(mkv(0, 1, 0, 0, 5, 1, 6,  1, 0, 0,   1, 0, -1, -1, 0));  // load-use stall
    tbl.push_back(mkv(0, 1, 0, 0, 5, 1, 6,  1, 0, 0,   0, 0, 0,  2,  1));  // released, fwd 2
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0,  0));  // mid-run reset
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 2,  1, 1, 0,   0, 0, 0,  0,  0));  // load r2
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 9,  1, 0, 0,   0, 0, 0,  0, -1));
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 2,  1, 0, 0,   0, 0, 0,  0, -1));  // alu r2
    tbl.push_back(mkv(0, 1, 2, 1, 0, 0, 7,  1, 0, 0,   0, 0, 1,  0, -1));  // youngest alu wins
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 2,  1, 0, 0,   0, 0, 0,  0, -1));  // alu r2
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 11, 1, 0, 0,   0, 0, 0,  0, -1));
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 2,  1, 1, 0,   0, 0, 0,  0, -1));  // load r2
    tbl.push_back(mkv(0, 1, 2, 1, 0, 0, 7,  1, 0, 0,   1, 0, -1, -1, 0));  // youngest load stalls
    tbl.push_back(mkv(0, 1, 2, 1, 0, 0, 7,  1, 0, 0,   0, 0, 2,  0,  1));
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 12, 1, 0, 0,   0, 0, 0,  0,  1));  // jump, links r12
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 8,  1, 1, 0,   0, 0, 0,  0, -1));  // load r8
    tbl.push_back(mkv(0, 1, 8, 1, 0, 0, 13, 1, 0, 1,   0, 1, 1,  0,  1));  // jump beats stall
    tbl.push_back(mkv(0, 1, 8, 1, 12, 1, 0, 0, 0, 0,   0, 0, 0,  3,  1));  // young killed, jump@2
    tbl.push_back(mkv(1, 0, 8, 1, 0, 0, 0,  0, 0, 1,   0, 1, 0,  0,  0));  // flush follows jmp in reset

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i]);
      expect_val($sformatf("row%0d.stall", i), 0, S_STALL, tbl[i].st);
      expect_val($sformatf("row%0d.flush", i), 0, S_FLUSH, tbl[i].fl);
      expect_val($sformatf("row%0d.fwd_a", i), 0, S_FA, tbl[i].fa);
      expect_val($sformatf("row%0d.fwd_b", i), 0, S_FB, tbl[i].fb);
      expect_val($sformatf("row%0d.cnt", i), 0, S_CNT, tbl[i].cnt);
      settle();
    end

    // Register 0 hardwired vs ordinary.
    drv(mkv(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    settle();
    drv(mkv(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    expect_val("r0.alu.fwd_a", 0, S_FA, 1);
    expect_val("r0.alu.stall", 0, S_STALL, 0);
    expect_val("r0z.alu.fwd_a", 1, S_FA, 0);
    expect_val("r0z.alu.stall", 1, S_STALL, 0);
    settle();
    drv(mkv(0, 1, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    expect_val("r0.load.stall", 0, S_STALL, 1);
    expect_val("r0z.load.stall", 1, S_STALL, 0);
    expect_val("r0z.load.fwd_b", 1, S_FB, 0);
    settle();

    // Chain of ten load-use hazards; the 3-bit counter saturates at 7.
    drv(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    settle();
    drv(mkv(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    expect_val("chain.first", 2, S_STALL, 0);
    settle();
    for (int k = 0; k < 10; k++) begin
      drv(mkv(0, 1, 4'(k + 1), 1, 0, 0, 4'(k + 2), 1, 1, 0, 0, 0, 0, 0, 0));
      expect_val($sformatf("chain%0d.stall", k), 0, S_STALL, 1);
      expect_val($sformatf("chain%0d.stall3", k), 2, S_STALL, 1);
      expect_val($sformatf("chain%0d.cnt", k), 0, S_CNT, k);
      expect_val($sformatf("chain%0d.cnt3", k), 2, S_CNT, (k > 7) ? 7 : k);
      settle();
      drv(mkv(0, 1, 4'(k + 1), 1, 0, 0, 4'(k + 2), 1, 1, 0, 0, 0, 0, 0, 0));
      expect_val($sformatf("chain%0d.go", k), 0, S_STALL, 0);
      expect_val($sformatf("chain%0d.fwd_a", k), 0, S_FA, 2);
      expect_val($sformatf("chain%0d.cnt3b", k), 2, S_CNT, (k + 1 > 7) ? 7 : k + 1);
      settle();
    end
    drv(mkv(0, 1, 11, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_val("pre_rst.stall", 0, S_STALL, 1);
    expect_val("pre_rst.cnt", 0, S_CNT, 10);
    expect_val("pre_rst.cnt3", 2, S_CNT, 7);
    settle();
    rst = 1'b1;   // between clock edges
    #1;
    expect_val("async_rst.stall", 0, S_STALL, 0);
    expect_val("async_rst.fwd_a", 0, S_FA, 0);
    expect_val("async_rst.fwd_b", 0, S_FB, 0);
    expect_val("async_rst.cnt", 0, S_CNT, 0);
    expect_val("async_rst.cnt3", 2, S_CNT, 0);
    expect_val("async_rst.fwd_a3", 2, S_FA, 0);
    check_all();
    drv(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
